// File: rtl/gpio_port_in.sv
// gpio_port_in: input half of a GPIO port. Pad levels are synchronized, optionally
// glitch-filtered, edge-detected into sticky flags and presented as a priority vector.
module gpio_port_in #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0
) (
    input  logic             MCLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] PIN,
    input  logic [WIDTH-1:0] IES,
    input  logic [WIDTH-1:0] IE,
    input  logic             IFG_WR,
    input  logic [WIDTH-1:0] IFG_WDATA,
    input  logic             IV_RD,
    output logic [WIDTH-1:0] PIN_IN,
    output logic [WIDTH-1:0] IFG,
    output logic [4:0]       IV,
    output logic             IRQ
);

    localparam int ARM_CYCLES = SYNC_STAGES + FILTER_CYCLES + 1;
    localparam int AW         = $clog2(ARM_CYCLES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] ifg_q;
    logic [WIDTH-1:0] ifg_next;
    logic [AW-1:0]    arm_cnt;
    logic             armed;
    logic [4:0]       iv;

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= PIN;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (FILTER_CYCLES == 0) begin : g_nofilt
            assign PIN_IN = s;
        end else begin : g_filt
            localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
            logic [CW-1:0]    cnt [WIDTH];
            logic [WIDTH-1:0] level_q;

            // A bit's new level is accepted only after it has disagreed with the
            // current level for FILTER_CYCLES consecutive cycles.
            always_ff @(posedge MCLK or posedge reset) begin
                if (reset) begin
                    level_q <= '0;
                    for (int b = 0; b < WIDTH; b++) begin
                        cnt[b] <= '0;
                    end
                end else begin
                    for (int b = 0; b < WIDTH; b++) begin
                        if (s[b] == level_q[b]) begin
                            cnt[b] <= '0;
                        end else if (cnt[b] == CW'(FILTER_CYCLES - 1)) begin
                            level_q[b] <= s[b];
                            cnt[b]     <= '0;
                        end else begin
                            cnt[b] <= cnt[b] + 1'b1;
                        end
                    end
                end
            end

            assign PIN_IN = level_q;
        end
    endgenerate

    // Edges are ignored until the pipeline has flushed the reset-time pad levels.
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            arm_cnt <= '0;
            prev_q  <= '0;
            ifg_q   <= '0;
        end else begin
            if (!armed) begin
                arm_cnt <= arm_cnt + 1'b1;
            end
            prev_q <= PIN_IN;
            ifg_q  <= ifg_next;
        end
    end

    assign armed   = (arm_cnt == AW'(ARM_CYCLES));
    assign rise    = PIN_IN & ~prev_q;
    assign fall    = ~PIN_IN & prev_q;
    assign evt     = ((IES & fall) | (~IES & rise)) & {WIDTH{armed}};
    assign pending = ifg_q & IE;

    // Scanning from the top down leaves the lowest pending bit as the winner.
    always_comb begin
        iv       = '0;
        clr_mask = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                iv          = 5'(2 * (i + 1));
                clr_mask    = '0;
                clr_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ifg_next = ifg_q;
        if (IFG_WR) begin
            ifg_next = IFG_WDATA;
        end else if (IV_RD && (iv != 5'd0)) begin
            ifg_next = ifg_q & ~clr_mask;
        end
        ifg_next = ifg_next | evt;
    end

    assign IFG = ifg_q;
    assign IV  = iv;
    assign IRQ = |pending;

endmodule

// File: tb/tb_gpio_port_in.sv
// tb_gpio_port_in: checks an unfiltered and a 3-cycle-filtered port against a
// window-based reference model, a directed vector table and hand-written sequences.
module tb_gpio_port_in;

    localparam int SYNC = 2;

    logic       MCLK = 1'b0;
    logic       reset;
    logic [7:0] PIN, IES, IE, IFG_WDATA;
    logic       IFG_WR, IV_RD;

    logic [7:0] pin_in0, ifg0, pin_in3, ifg3;
    logic [4:0] iv0, iv3;
    logic       irq0, irq3;

    int errors = 0;
    int checks = 0;

    gpio_port_in #(.WIDTH(8), .SYNC_STAGES(SYNC), .FILTER_CYCLES(0)) u_nf (
        .MCLK(MCLK), .reset(reset), .PIN(PIN), .IES(IES), .IE(IE),
        .IFG_WR(IFG_WR), .IFG_WDATA(IFG_WDATA), .IV_RD(IV_RD),
        .PIN_IN(pin_in0), .IFG(ifg0), .IV(iv0), .IRQ(irq0)
    );

    gpio_port_in #(.WIDTH(8), .SYNC_STAGES(SYNC), .FILTER_CYCLES(3)) u_f3 (
        .MCLK(MCLK), .reset(reset), .PIN(PIN), .IES(IES), .IE(IE),
        .IFG_WR(IFG_WR), .IFG_WDATA(IFG_WDATA), .IV_RD(IV_RD),
        .PIN_IN(pin_in3), .IFG(ifg3), .IV(iv3), .IRQ(irq3)
    );

    always #5 MCLK = ~MCLK;

    // Reference model: pad history plus a sliding window of synchronized levels.
    int         edges;
    logic [7:0] pin_q [$];
    logic [7:0] s_q [$];
    logic [7:0] m_cur [2];
    logic [7:0] m_prev [2];
    logic [7:0] m_ifg [2];
    int         filt [2] = '{0, 3};

    function automatic logic [4:0] vec_of(input logic [7:0] f, input logic [7:0] e);
        for (int i = 0; i < 8; i++) begin
            if (f[i] && e[i]) return 5'(2 * (i + 1));
        end
        return 5'd0;
    endfunction

    task automatic model_reset();
        edges = 0;
        pin_q.delete();
        s_q.delete();
        s_q.push_back(8'h00);
        for (int k = 0; k < 2; k++) begin
            m_cur[k]  = 8'h00;
            m_prev[k] = 8'h00;
            m_ifg[k]  = 8'h00;
        end
    endtask

    task automatic model_edge();
        logic [7:0] s_new, rise, fall, evt, nxt, want;
        logic [4:0] v;
        edges++;
        pin_q.push_back(PIN);
        s_new = (edges >= SYNC) ? pin_q[edges - SYNC] : 8'h00;
        for (int k = 0; k < 2; k++) begin
            rise = m_cur[k] & ~m_prev[k];
            fall = ~m_cur[k] & m_prev[k];
            evt  = (edges - 1 >= SYNC + filt[k] + 1) ? ((IES & fall) | (~IES & rise)) : 8'h00;
            v    = vec_of(m_ifg[k], IE);
            if (IFG_WR) nxt = IFG_WDATA;
            else if (IV_RD && v != 5'd0) nxt = m_ifg[k] & ~(8'h01 << (v / 2 - 1));
            else nxt = m_ifg[k];
            m_ifg[k] = nxt | evt;
            if (filt[k] == 0) begin
                want = s_new;
            end else begin
                want = m_cur[k];
                for (int b = 0; b < 8; b++) begin
                    logic ok;
                    ok = 1'b1;
                    for (int j = edges - filt[k]; j < edges; j++) begin
                        logic sv;
                        sv = (j >= 0) ? s_q[j][b] : 1'b0;
                        if (sv == m_cur[k][b]) ok = 1'b0;
                    end
                    if (ok) want[b] = ~m_cur[k][b];
                end
            end
            m_prev[k] = m_cur[k];
            m_cur[k]  = want;
        end
        s_q.push_back(s_new);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        check("pin_in0", pin_in0, m_cur[0]);
        check("ifg0", ifg0, m_ifg[0]);
        check("iv0", {3'b0, iv0}, {3'b0, vec_of(m_ifg[0], IE)});
        check("irq0", {7'b0, irq0}, {7'b0, |(m_ifg[0] & IE)});
        check("pin_in3", pin_in3, m_cur[1]);
        check("ifg3", ifg3, m_ifg[1]);
        check("iv3", {3'b0, iv3}, {3'b0, vec_of(m_ifg[1], IE)});
        check("irq3", {7'b0, irq3}, {7'b0, |(m_ifg[1] & IE)});
    endtask

    task automatic tick();
        @(posedge MCLK);
        if (reset) model_reset();
        else model_edge();
        @(negedge MCLK);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [7:0] pin, input logic [7:0] ies,
                                 input logic [7:0] ie, input logic wr,
                                 input logic [7:0] wdata, input logic rd);
        PIN       = pin;
        IES       = ies;
        IE        = ie;
        IFG_WR    = wr;
        IFG_WDATA = wdata;
        IV_RD     = rd;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pin_in0"}, pin_in0, 8'h00);
        check({tag, "_ifg0"}, ifg0, 8'h00);
        check({tag, "_iv0"}, {3'b0, iv0}, 8'h00);
        check({tag, "_irq0"}, {7'b0, irq0}, 8'h00);
        check({tag, "_pin_in3"}, pin_in3, 8'h00);
        check({tag, "_ifg3"}, ifg3, 8'h00);
        check({tag, "_iv3"}, {3'b0, iv3}, 8'h00);
        check({tag, "_irq3"}, {7'b0, irq3}, 8'h00);
    endtask

    typedef struct {
        logic [7:0] pin, ies, ie;
        logic       wr;
        logic [7:0] wdata;
        logic       rd;
        logic [7:0] e_pin_in, e_ifg;
        logic [4:0] e_iv;
        logic       e_irq;
    } vec_t;

    vec_t tbl [27];

    initial begin
        logic [7:0] rp;
        // One record per clock edge for the unfiltered port, starting at reset release.
        tbl[0]  = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 5'd0,  1'b0};
        tbl[1]  = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 5'd0,  1'b0};
        tbl[2]  = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 5'd0,  1'b0};
        tbl[3]  = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 5'd0,  1'b0};
        tbl[4]  = '{8'hFE, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 5'd0,  1'b0};
        tbl[5]  = '{8'hFE, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 8'hFE, 8'h00, 5'd0,  1'b0};
        tbl[6]  = '{8'hFE, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 8'hFE, 8'h00, 5'd0,  1'b0};
        tbl[7]  = '{8'hFF, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 8'hFE, 8'h00, 5'd0,  1'b0};
        tbl[8]  = '{8'hFF, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 5'd0,  1'b0};
        tbl[9]  = '{8'hFF, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h01, 5'd2,  1'b1};
        tbl[10] = '{8'hFF, 8'h00, 8'h01, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h00, 5'd0,  1'b0};
        tbl[11] = '{8'hFF, 8'h00, 8'hFF, 1'b1, 8'h12, 1'b0, 8'hFF, 8'h12, 5'd4,  1'b1};
        tbl[12] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h10, 5'd10, 1'b1};
        tbl[13] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h00, 5'd0,  1'b0};
        tbl[14] = '{8'hFF, 8'h00, 8'h80, 1'b1, 8'h81, 1'b0, 8'hFF, 8'h81, 5'd16, 1'b1};
        tbl[15] = '{8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h81, 5'd0,  1'b0};
        tbl[16] = '{8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h81, 5'd0,  1'b0};
        tbl[17] = '{8'hFF, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 8'hFF, 8'h00, 5'd0,  1'b0};
        tbl[18] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 5'd0,  1'b0};
        tbl[19] = '{8'hDF, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h00, 5'd0,  1'b0};
        tbl[20] = '{8'hDF, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hDF, 8'h00, 5'd0,  1'b0};
        tbl[21] = '{8'hDF, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 8'hDF, 8'h20, 5'd12, 1'b1};
        tbl[22] = '{8'hDF, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hDF, 8'h20, 5'd12, 1'b1};
        tbl[23] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hDF, 8'h20, 5'd12, 1'b1};
        tbl[24] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hFF, 8'h20, 5'd12, 1'b1};
        tbl[25] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h20, 5'd12, 1'b1};
        tbl[26] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b1, 8'hFF, 8'h00, 5'd0,  1'b0};

        reset = 1'b1;
        PIN = 8'hFF; IES = 8'h00; IE = 8'hFF; IFG_WR = 1'b0; IFG_WDATA = 8'h00; IV_RD = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < 27; i++) begin
            applyStimulus(tbl[i].pin, tbl[i].ies, tbl[i].ie, tbl[i].wr, tbl[i].wdata, tbl[i].rd);
            check($sformatf("tbl%0d_pin_in", i), pin_in0, tbl[i].e_pin_in);
            check($sformatf("tbl%0d_ifg", i), ifg0, tbl[i].e_ifg);
            check($sformatf("tbl%0d_iv", i), {3'b0, iv0}, {3'b0, tbl[i].e_iv});
            check($sformatf("tbl%0d_irq", i), {7'b0, irq0}, {7'b0, tbl[i].e_irq});
        end

        // Filtered port: a 2-cycle pulse is swallowed, a 4-cycle pulse gets through.
        reset = 1'b1;
        model_reset();
        applyStimulus(8'h00, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) applyStimulus(8'h00, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0);
        for (int c = 0; c < 8; c++) begin
            applyStimulus((c < 2) ? 8'h08 : 8'h00, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0);
            check("f3_short_pin_in", pin_in3, 8'h00);
            check("f3_short_ifg", ifg3, 8'h00);
        end
        for (int c = 0; c < 10; c++) begin
            applyStimulus((c < 4) ? 8'h08 : 8'h00, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0);
            check("f3_long_pin_in", pin_in3, (c >= 4 && c <= 7) ? 8'h08 : 8'h00);
            check("f3_long_ifg", ifg3, (c >= 5) ? 8'h08 : 8'h00);
        end

        // Async reset in the middle of a filter count with all flags set.
        applyStimulus(8'h00, 8'h00, 8'hFF, 1'b1, 8'hFF, 1'b0);
        check("pre_reset_ifg0", ifg0, 8'hFF);
        check("pre_reset_ifg3", ifg3, 8'hFF);
        applyStimulus(8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0);
        applyStimulus(8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0);
        applyStimulus(8'hFF, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all_zero("async_reset");
        tick();
        reset = 1'b0;

        // Randomized traffic against the model, with one mid-run reset.
        rp = 8'h00;
        for (int n = 0; n < 600; n++) begin
            int idx;
            if ($urandom_range(3, 0) == 0) begin
                idx = $urandom_range(7, 0);
                rp[idx] = ~rp[idx];
            end
            if ($urandom_range(31, 0) == 0) IES = 8'($urandom);
            if ($urandom_range(31, 0) == 0) IE = 8'($urandom);
            if (n == 300) begin
                #2;
                reset = 1'b1;
                model_reset();
                tick();
                tick();
                reset = 1'b0;
            end
            applyStimulus(rp, IES, IE, ($urandom_range(15, 0) == 0), 8'($urandom),
                          ($urandom_range(3, 0) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
